// File: rtl/jtkicker_snd_fifo.sv
// Main-to-sound command FIFO: queues main CPU writes, pops on the trailing edge of the
// sound CPU latch read, and drives the sound CPU interrupt in level or edge mode.
module jtkicker_snd_fifo #(
    parameter int DW        = 8,
    parameter int AW        = 2,
    parameter int IRQ_LEVEL = 0,
    parameter int HOLD_LAST = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] main_dout,
    input  logic          m2s_wr,
    input  logic          snd_rd,
    input  logic          irq_ack,
    input  logic          stat_rd,
    output logic [DW-1:0] snd_dout,
    output logic          int_n,
    output logic [AW:0]   fill,
    output logic          empty,
    output logic          full,
    output logic          ovf
);

    localparam int            DEPTH     = 1 << AW;
    localparam int            PW        = (AW == 0) ? 1 : AW;
    localparam logic [AW:0]   FULL_CNT  = (AW+1)'(DEPTH);
    localparam logic [AW:0]   ONE       = (AW+1)'(1);
    // With a single entry the pointers never move, so the increment collapses to zero.
    localparam logic [PW-1:0] PINC      = (AW == 0) ? PW'(0) : PW'(1);
    localparam logic [DW-1:0] RESET_OUT = {DW{HOLD_LAST == 0}};

    // Strobe semantics: m2s_wr pushes once per high cycle; snd_rd and stat_rd act on
    // their falling edge so the CPU sees stable data for the whole bus cycle.
    logic [DW-1:0] mem [0:(1<<PW)-1];
    logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr_next, rd_ptr_next;
    logic [AW:0]   fill_next;
    logic          snd_rd_l, stat_rd_l;
    logic          pending, pending_next;
    logic          pop_edge, clr_edge;
    logic          do_push, do_pop, overflow;
    logic [DW-1:0] head_next, dout_next;
    logic          int_n_next;

    always_comb begin
        pop_edge = snd_rd_l & ~snd_rd;
        clr_edge = stat_rd_l & ~stat_rd;
        do_pop   = pop_edge & ~empty;
        // A pop in the same cycle frees a slot, so a write to a full FIFO still lands.
        do_push  = m2s_wr & (~full | do_pop);
        overflow = m2s_wr & full & ~do_pop;
    end

    always_comb begin
        fill_next   = fill;
        wr_ptr_next = wr_ptr;
        rd_ptr_next = rd_ptr;
        if (do_push) wr_ptr_next = wr_ptr + PINC;
        if (do_pop)  rd_ptr_next = rd_ptr + PINC;
        case ({do_push, do_pop})
            2'b10:   fill_next = fill + ONE;
            2'b01:   fill_next = fill - ONE;
            default: fill_next = fill;
        endcase
    end

    always_comb begin
        // The entry being written this cycle becomes the head when it lands in the head slot.
        head_next = mem[rd_ptr_next];
        if (do_push && (wr_ptr == rd_ptr_next)) head_next = main_dout;
        dout_next = snd_dout;
        if (fill_next != '0)     dout_next = head_next;
        else if (HOLD_LAST == 0) dout_next = '1;
    end

    always_comb begin
        pending_next = pending;
        if (irq_ack) pending_next = 1'b0;
        if (do_push) pending_next = 1'b1;
        if (IRQ_LEVEL != 0) int_n_next = (fill_next == '0);
        else                int_n_next = ~pending_next;
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= main_dout;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fill      <= '0;
            empty     <= 1'b1;
            full      <= 1'b0;
            ovf       <= 1'b0;
            pending   <= 1'b0;
            int_n     <= 1'b1;
            snd_dout  <= RESET_OUT;
            snd_rd_l  <= 1'b0;
            stat_rd_l <= 1'b0;
        end else begin
            wr_ptr    <= wr_ptr_next;
            rd_ptr    <= rd_ptr_next;
            fill      <= fill_next;
            empty     <= (fill_next == '0);
            full      <= (fill_next == FULL_CNT);
            pending   <= pending_next;
            int_n     <= int_n_next;
            snd_dout  <= dout_next;
            snd_rd_l  <= snd_rd;
            stat_rd_l <= stat_rd;
            // Setting wins over a same-cycle status-read clear.
            if (overflow)      ovf <= 1'b1;
            else if (clr_edge) ovf <= 1'b0;
        end
    end

endmodule
